// File: rtl/c2f_consumer_arbiter_if.sv
// ---------------------------------------------------------------------------
// c2f_consumer_arbiter_if
//   Bundles the signals between the C2F chunk-ring arbiter, the transceiver's
//   C2F buffer and the two chunk consumers.
//
//   Ring side   : wrPtr_in, rdPtr_out, rdOffset_out, rdData_in
//   Consumers   : enable_in, c{0,1}WrPtr_out, c{0,1}RdPtr_out, c{0,1}DtAck_in,
//                 c{0,1}RdOffset_in, c{0,1}RdData_out
//   Status      : grant_out, retired_out, protoErr_out
//
//   modport master : the arbiter (drives every *_out signal)
//   modport slave  : the surrounding logic (drives every *_in signal)
// ---------------------------------------------------------------------------
interface c2f_consumer_arbiter_if #(
    parameter int PTR_W  = 2,
    parameter int OFF_W  = 4,
    parameter int DATA_W = 64
);
    // Ring (transceiver C2F buffer) side
    logic [PTR_W-1:0]  wrPtr_in;
    logic [PTR_W-1:0]  rdPtr_out;
    logic [OFF_W-1:0]  rdOffset_out;
    logic [DATA_W-1:0] rdData_in;

    // Consumer side
    logic [1:0]        enable_in;
    logic [PTR_W-1:0]  c0WrPtr_out;
    logic [PTR_W-1:0]  c1WrPtr_out;
    logic [PTR_W-1:0]  c0RdPtr_out;
    logic [PTR_W-1:0]  c1RdPtr_out;
    logic              c0DtAck_in;
    logic              c1DtAck_in;
    logic [OFF_W-1:0]  c0RdOffset_in;
    logic [OFF_W-1:0]  c1RdOffset_in;
    logic [DATA_W-1:0] c0RdData_out;
    logic [DATA_W-1:0] c1RdData_out;

    // Status
    logic [1:0]        grant_out;
    logic [31:0]       retired_out;
    logic              protoErr_out;

    modport master (
        input  wrPtr_in, rdData_in, enable_in,
               c0DtAck_in, c1DtAck_in, c0RdOffset_in, c1RdOffset_in,
        output rdPtr_out, rdOffset_out,
               c0WrPtr_out, c1WrPtr_out, c0RdPtr_out, c1RdPtr_out,
               c0RdData_out, c1RdData_out,
               grant_out, retired_out, protoErr_out
    );

    modport slave (
        output wrPtr_in, rdData_in, enable_in,
               c0DtAck_in, c1DtAck_in, c0RdOffset_in, c1RdOffset_in,
        input  rdPtr_out, rdOffset_out,
               c0WrPtr_out, c1WrPtr_out, c0RdPtr_out, c1RdPtr_out,
               c0RdData_out, c1RdData_out,
               grant_out, retired_out, protoErr_out
    );
endinterface

// File: rtl/c2f_consumer_arbiter.sv
// ---------------------------------------------------------------------------
// c2f_consumer_arbiter
//   Shares the single host-to-FPGA chunk ring between two consumers. Whole
//   chunks are granted round-robin, one consumer at a time; the block owns
//   the ring read pointer and advances it when the granted consumer
//   acknowledges its chunk.
//
//   sysClk_in   : system clock, rising edge
//   sysRstN_in  : asynchronous active-low reset
//   arbIf       : ring, consumer and status signals (master modport)
// ---------------------------------------------------------------------------
module c2f_consumer_arbiter #(
    parameter int PTR_W  = 2,
    parameter int OFF_W  = 4,
    parameter int DATA_W = 64
) (
    input  logic                    sysClk_in,
    input  logic                    sysRstN_in,
    c2f_consumer_arbiter_if.master  arbIf
);

    typedef enum logic { S_IDLE, S_GRANT } state_t;

    state_t            state, stateNxt;
    logic              grantSel, grantSelNxt;   // 0: consumer 0, 1: consumer 1
    logic              prioSel, prioSelNxt;     // preferred consumer when both enabled
    logic [PTR_W-1:0]  rdPtr, rdPtrNxt;
    logic [31:0]       retired, retiredNxt;
    logic              protoErr, protoErrNxt;

    logic              granted;
    logic              ackGranted;
    logic              ackOther;
    logic [OFF_W-1:0]  grantedOffset;
    logic [DATA_W-1:0] rdDataBcast;

    assign granted    = (state == S_GRANT);
    assign ackGranted = grantSel ? arbIf.c1DtAck_in : arbIf.c0DtAck_in;
    assign ackOther   = grantSel ? arbIf.c0DtAck_in : arbIf.c1DtAck_in;

    // NOTE: every register resets asynchronously so that a reset mid-chunk
    // drops the grant at once; rdPtr returns to 0 and the chunk is re-granted.
    always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
        if (!sysRstN_in) begin
            state    <= S_IDLE;
            grantSel <= 1'b0;
            prioSel  <= 1'b0;
            rdPtr    <= '0;
            retired  <= '0;
            protoErr <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block below.
            state    <= stateNxt;
            grantSel <= grantSelNxt;
            prioSel  <= prioSelNxt;
            rdPtr    <= rdPtrNxt;
            retired  <= retiredNxt;
            protoErr <= protoErrNxt;
        end
    end

    always_comb begin
        // NOTE: hold-current defaults first, so no path leaves a value
        // unassigned and no latch is inferred.
        stateNxt    = state;
        grantSelNxt = grantSel;
        prioSelNxt  = prioSel;
        rdPtrNxt    = rdPtr;
        retiredNxt  = retired;
        protoErrNxt = protoErr;

        case (state)
            S_IDLE: begin
                // Nobody owns a chunk, so any acknowledge is a protocol error.
                if (arbIf.c0DtAck_in || arbIf.c1DtAck_in) begin
                    protoErrNxt = 1'b1;
                end
                if ((arbIf.wrPtr_in != rdPtr) && (arbIf.enable_in != 2'b00)) begin
                    stateNxt    = S_GRANT;
                    grantSelNxt = (arbIf.enable_in == 2'b11) ? prioSel
                                                             : arbIf.enable_in[1];
                end
            end
            S_GRANT: begin
                if (ackOther) begin
                    protoErrNxt = 1'b1;
                end
                // enable_in is deliberately ignored here: a grant runs until
                // its own acknowledge.
                if (ackGranted) begin
                    rdPtrNxt   = rdPtr + PTR_W'(1);
                    retiredNxt = retired + 32'd1;
                    prioSelNxt = ~grantSel;
                    stateNxt   = S_IDLE;
                end
            end
            default: stateNxt = S_IDLE;
        endcase
    end

    // Only the granted consumer sees the live write pointer; everyone else
    // sees wrPtr == rdPtr, i.e. an empty ring.
    assign arbIf.c0WrPtr_out = (granted && !grantSel) ? arbIf.wrPtr_in : rdPtr;
    assign arbIf.c1WrPtr_out = (granted &&  grantSel) ? arbIf.wrPtr_in : rdPtr;
    assign arbIf.c0RdPtr_out = rdPtr;
    assign arbIf.c1RdPtr_out = rdPtr;

    // Read address passes straight through from the owner: no added latency.
    assign grantedOffset      = grantSel ? arbIf.c1RdOffset_in : arbIf.c0RdOffset_in;
    assign arbIf.rdOffset_out = granted ? grantedOffset : '0;

    assign rdDataBcast        = arbIf.rdData_in;
    assign arbIf.c0RdData_out = rdDataBcast;
    assign arbIf.c1RdData_out = rdDataBcast;

    assign arbIf.rdPtr_out    = rdPtr;
    assign arbIf.grant_out    = granted ? (grantSel ? 2'b10 : 2'b01) : 2'b00;
    assign arbIf.retired_out  = retired;
    assign arbIf.protoErr_out = protoErr;

endmodule

// File: tb/tb_c2f_consumer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_c2f_consumer_arbiter
//   Self-checking bench for c2f_consumer_arbiter: directed scenarios plus
//   randomized traffic compared against a chunk-level behavioural model
//   (owner, round-robin preference, chunks retired, sticky error flag).
// ---------------------------------------------------------------------------
module tb_c2f_consumer_arbiter;

    localparam int PTR_W  = 2;
    localparam int OFF_W  = 4;
    localparam int DATA_W = 64;
    localparam int RING   = 1 << PTR_W;

    logic sysClk  = 1'b0;
    logic sysRstN = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    c2f_consumer_arbiter_if #(.PTR_W(PTR_W), .OFF_W(OFF_W), .DATA_W(DATA_W)) arbIf ();

    c2f_consumer_arbiter #(.PTR_W(PTR_W), .OFF_W(OFF_W), .DATA_W(DATA_W)) dut (
        .sysClk_in  (sysClk),
        .sysRstN_in (sysRstN),
        .arbIf      (arbIf)
    );

    always #5 sysClk = ~sysClk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic [1:0]        grant;
        logic [PTR_W-1:0]  rdPtr;
        logic [31:0]       retired;
        logic              protoErr;
        logic [OFF_W-1:0]  rdOffset;
        logic [PTR_W-1:0]  c0Wr;
        logic [PTR_W-1:0]  c0Rd;
        logic [PTR_W-1:0]  c1Wr;
        logic [PTR_W-1:0]  c1Rd;
        logic [DATA_W-1:0] c0Data;
        logic [DATA_W-1:0] c1Data;
    } obs_t;

    // ---------------- reference model (chunk level) ----------------
    int          mOwner;    // -1: nobody holds a chunk
    int          mPrio;     // consumer preferred when both are enabled
    logic [31:0] mRetired;  // chunks retired since reset
    bit          mErr;

    // The read pointer is just the number of retired chunks modulo ring size.
    function automatic logic [PTR_W-1:0] m_rd_ptr();
        return PTR_W'(mRetired % RING);
    endfunction

    function automatic void model_reset();
        mOwner   = -1;
        mPrio    = 0;
        mRetired = '0;
        mErr     = 1'b0;
    endfunction

    function automatic void model_clock();
        bit a0, a1, ownAck, othAck;
        logic [1:0] en;
        a0 = arbIf.c0DtAck_in;
        a1 = arbIf.c1DtAck_in;
        en = arbIf.enable_in;
        if (mOwner < 0) begin
            if (a0 || a1) mErr = 1'b1;
            if (arbIf.wrPtr_in != m_rd_ptr() && en != 2'b00)
                mOwner = (en == 2'b11) ? mPrio : (en[0] ? 0 : 1);
        end else begin
            ownAck = (mOwner == 0) ? a0 : a1;
            othAck = (mOwner == 0) ? a1 : a0;
            if (othAck) mErr = 1'b1;
            if (ownAck) begin
                mRetired = mRetired + 32'd1;
                mPrio    = 1 - mOwner;
                mOwner   = -1;
            end
        end
    endfunction

    function automatic obs_t exp_obs();
        obs_t o;
        logic [PTR_W-1:0] rp;
        rp         = m_rd_ptr();
        o.grant    = (mOwner < 0) ? 2'b00 : ((mOwner == 0) ? 2'b01 : 2'b10);
        o.rdPtr    = rp;
        o.retired  = mRetired;
        o.protoErr = mErr;
        o.rdOffset = (mOwner == 0) ? arbIf.c0RdOffset_in :
                     (mOwner == 1) ? arbIf.c1RdOffset_in : '0;
        o.c0Wr     = (mOwner == 0) ? arbIf.wrPtr_in : rp;
        o.c0Rd     = rp;
        o.c1Wr     = (mOwner == 1) ? arbIf.wrPtr_in : rp;
        o.c1Rd     = rp;
        o.c0Data   = arbIf.rdData_in;
        o.c1Data   = arbIf.rdData_in;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.grant    = arbIf.grant_out;
        o.rdPtr    = arbIf.rdPtr_out;
        o.retired  = arbIf.retired_out;
        o.protoErr = arbIf.protoErr_out;
        o.rdOffset = arbIf.rdOffset_out;
        o.c0Wr     = arbIf.c0WrPtr_out;
        o.c0Rd     = arbIf.c0RdPtr_out;
        o.c1Wr     = arbIf.c1WrPtr_out;
        o.c1Rd     = arbIf.c1RdPtr_out;
        o.c0Data   = arbIf.c0RdData_out;
        o.c1Data   = arbIf.c1RdData_out;
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sysClk);
        if (sysRstN) model_clock();
        @(negedge sysClk);
    endtask

    task automatic clear_inputs();
        arbIf.wrPtr_in      = '0;
        arbIf.rdData_in     = {$urandom, $urandom};
        arbIf.enable_in     = 2'b00;
        arbIf.c0DtAck_in    = 1'b0;
        arbIf.c1DtAck_in    = 1'b0;
        arbIf.c0RdOffset_in = '0;
        arbIf.c1RdOffset_in = '0;
    endtask

    task automatic apply_reset();
        sysRstN = 1'b0;
        model_reset();
        clear_inputs();
        tick();
        tick();
        sysRstN = 1'b1;
    endtask

    task automatic pulse_ack(input int who);
        if (who == 0) arbIf.c0DtAck_in = 1'b1;
        else          arbIf.c1DtAck_in = 1'b1;
        tick();
        arbIf.c0DtAck_in = 1'b0;
        arbIf.c1DtAck_in = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        obs_t o;
        #1;
        o = dut_obs();
        vectors++;
        if (o.grant !== 2'b00 || o.rdPtr !== '0 || o.retired !== 32'd0 || o.protoErr !== 1'b0 ||
            o.rdOffset !== '0 || o.c0Wr !== '0 || o.c0Rd !== '0 || o.c1Wr !== '0 || o.c1Rd !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %h, want all-zero control outputs", o);
        end
        tick();
        sysRstN = 1'b1;
        tick();
        #1;
        vectors++;
        if (dut_obs() !== exp_obs()) begin
            miscompares++;
            $display("FAIL reset_idle_empty: got %h want %h", dut_obs(), exp_obs());
        end
    endtask

    task automatic test_first_chunk();
        obs_t o;
        apply_reset();
        arbIf.enable_in = 2'b11;
        arbIf.wrPtr_in  = 2'd1;
        #1;
        vectors++;
        if (arbIf.grant_out !== 2'b00) begin
            miscompares++;
            $display("FAIL grant_latency: grant=%b before edge, want 00", arbIf.grant_out);
        end
        tick();
        #1;
        o = dut_obs();
        vectors++;
        if (o.grant !== 2'b01 || o.c0Wr !== 2'd1 || o.c0Rd !== 2'd0 || o.c1Wr !== 2'd0 || o.c1Rd !== 2'd0) begin
            miscompares++;
            $display("FAIL first_grant: grant=%b c0=(%0d,%0d) c1=(%0d,%0d), want 01 c0=(1,0) c1=(0,0)",
                     o.grant, o.c0Wr, o.c0Rd, o.c1Wr, o.c1Rd);
        end
        pulse_ack(0);
        #1;
        o = dut_obs();
        vectors++;
        if (o.rdPtr !== 2'd1 || o.retired !== 32'd1 || o.grant !== 2'b00) begin
            miscompares++;
            $display("FAIL first_ack: rdPtr=%0d retired=%0d grant=%b, want 1 1 00", o.rdPtr, o.retired, o.grant);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] expG [3] = '{2'b01, 2'b10, 2'b01};
        apply_reset();
        arbIf.enable_in = 2'b11;
        arbIf.wrPtr_in  = 2'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            vectors++;
            if (arbIf.grant_out !== expG[k] || dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL rr_grant%0d: grant=%b want %b (obs %h model %h)", k, arbIf.grant_out, expG[k], dut_obs(), exp_obs());
            end
            repeat (4) tick();
            pulse_ack(expG[k][1] ? 1 : 0);
            #1;
            vectors++;
            if (arbIf.grant_out !== 2'b00) begin
                miscompares++;
                $display("FAIL rr_idle_gap%0d: grant=%b want 00", k, arbIf.grant_out);
            end
        end
        tick();
        #1;
        vectors++;
        if (arbIf.rdPtr_out !== 2'd3 || arbIf.retired_out !== 32'd3 || arbIf.grant_out !== 2'b00) begin
            miscompares++;
            $display("FAIL rr_end: rdPtr=%0d retired=%0d grant=%b, want 3 3 00",
                     arbIf.rdPtr_out, arbIf.retired_out, arbIf.grant_out);
        end
    endtask

    task automatic test_wrap_single_consumer();
        apply_reset();
        arbIf.enable_in = 2'b10;
        arbIf.wrPtr_in  = 2'd3;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) arbIf.wrPtr_in = 2'd0;
            tick();
            #1;
            vectors++;
            if (arbIf.grant_out !== 2'b10 || dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL wrap_grant%0d: grant=%b want 10 (obs %h model %h)", k, arbIf.grant_out, dut_obs(), exp_obs());
            end
            repeat (2) tick();
            pulse_ack(1);
            #1;
            vectors++;
            if (arbIf.rdPtr_out !== PTR_W'((k + 1) % RING) || arbIf.grant_out !== 2'b00) begin
                miscompares++;
                $display("FAIL wrap_ack%0d: rdPtr=%0d grant=%b, want %0d 00", k, arbIf.rdPtr_out, arbIf.grant_out, (k + 1) % RING);
            end
        end
        tick();
        #1;
        vectors++;
        if (arbIf.rdPtr_out !== 2'd0 || arbIf.retired_out !== 32'd4 || arbIf.grant_out !== 2'b00) begin
            miscompares++;
            $display("FAIL wrap_end: rdPtr=%0d retired=%0d grant=%b, want 0 4 00",
                     arbIf.rdPtr_out, arbIf.retired_out, arbIf.grant_out);
        end
    endtask

    task automatic test_offset_and_proto_err();
        apply_reset();
        arbIf.enable_in = 2'b11;
        arbIf.wrPtr_in  = 2'd1;
        tick();
        arbIf.c0RdOffset_in = 4'd5;
        arbIf.c1RdOffset_in = 4'd7;
        #1;
        vectors++;
        if (arbIf.rdOffset_out !== 4'd5) begin
            miscompares++;
            $display("FAIL offset_passthru: rdOffset=%0d want 5", arbIf.rdOffset_out);
        end
        pulse_ack(1);
        #1;
        vectors++;
        if (arbIf.protoErr_out !== 1'b1 || arbIf.rdPtr_out !== 2'd0 || arbIf.grant_out !== 2'b01 ||
            arbIf.retired_out !== 32'd0) begin
            miscompares++;
            $display("FAIL ungranted_ack: err=%b rdPtr=%0d grant=%b retired=%0d, want 1 0 01 0",
                     arbIf.protoErr_out, arbIf.rdPtr_out, arbIf.grant_out, arbIf.retired_out);
        end
        pulse_ack(0);
        #1;
        vectors++;
        if (arbIf.protoErr_out !== 1'b1 || arbIf.rdPtr_out !== 2'd1 || arbIf.rdOffset_out !== 4'd0) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b rdPtr=%0d rdOffset=%0d, want 1 1 0",
                     arbIf.protoErr_out, arbIf.rdPtr_out, arbIf.rdOffset_out);
        end
    endtask

    task automatic test_enable_drop_and_reset();
        apply_reset();
        arbIf.enable_in = 2'b11;
        arbIf.wrPtr_in  = 2'd2;
        tick();
        arbIf.enable_in = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            vectors++;
            if (arbIf.grant_out !== 2'b01) begin
                miscompares++;
                $display("FAIL enable_drop_hold%0d: grant=%b want 01", k, arbIf.grant_out);
            end
        end
        pulse_ack(0);
        tick();
        tick();
        #2;
        vectors++;
        if (arbIf.grant_out !== 2'b10 || arbIf.rdPtr_out !== 2'd1) begin
            miscompares++;
            $display("FAIL enable_drop_next: grant=%b rdPtr=%0d, want 10 1", arbIf.grant_out, arbIf.rdPtr_out);
        end
        sysRstN = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (arbIf.grant_out !== 2'b00 || arbIf.rdPtr_out !== 2'd0 || arbIf.retired_out !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset: grant=%b rdPtr=%0d retired=%0d, want 00 0 0",
                     arbIf.grant_out, arbIf.rdPtr_out, arbIf.retired_out);
        end
        tick();
        sysRstN = 1'b1;
        tick();
        #1;
        vectors++;
        if (arbIf.grant_out !== 2'b10 || arbIf.rdPtr_out !== 2'd0 || dut_obs() !== exp_obs()) begin
            miscompares++;
            $display("FAIL regrant_after_reset: grant=%b rdPtr=%0d, want 10 0", arbIf.grant_out, arbIf.rdPtr_out);
        end
    endtask

    task automatic test_random_traffic(input int cycles);
        apply_reset();
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 7) == 0)  arbIf.wrPtr_in  = PTR_W'($urandom);
            if ($urandom_range(0, 15) == 0) arbIf.enable_in = 2'($urandom);
            arbIf.c0RdOffset_in = OFF_W'($urandom);
            arbIf.c1RdOffset_in = OFF_W'($urandom);
            arbIf.rdData_in     = {$urandom, $urandom};
            arbIf.c0DtAck_in    = 1'b0;
            arbIf.c1DtAck_in    = 1'b0;
            if (mOwner >= 0 && $urandom_range(0, 3) == 0) begin
                if (mOwner == 0) arbIf.c0DtAck_in = 1'b1;
                else             arbIf.c1DtAck_in = 1'b1;
            end
            #1;
            vectors++;
            if (dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL random_traffic cyc %0d: got %h want %h", c, dut_obs(), exp_obs());
            end
            tick();
        end
    endtask

    task automatic test_random_errors(input int cycles);
        apply_reset();
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                sysRstN = 1'b0;
                model_reset();
            end else begin
                sysRstN = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) arbIf.wrPtr_in  = PTR_W'($urandom);
            if ($urandom_range(0, 9) == 0) arbIf.enable_in = 2'($urandom);
            arbIf.c0RdOffset_in = OFF_W'($urandom);
            arbIf.c1RdOffset_in = OFF_W'($urandom);
            arbIf.rdData_in     = {$urandom, $urandom};
            arbIf.c0DtAck_in    = ($urandom_range(0, 5) == 0);
            arbIf.c1DtAck_in    = ($urandom_range(0, 5) == 0);
            #1;
            vectors++;
            if (dut_obs() !== exp_obs()) begin
                miscompares++;
                $display("FAIL random_errors cyc %0d: got %h want %h", c, dut_obs(), exp_obs());
            end
            tick();
        end
        sysRstN = 1'b1;
    endtask

    initial begin
        sysRstN = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_first_chunk();
        test_round_robin();
        test_wrap_single_consumer();
        test_offset_and_proto_err();
        test_enable_drop_and_reset();
        test_random_traffic(600);
        test_random_errors(400);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
